sel_status_tx: RTL and testbench

- Serial status transmitter for the 6x2 antenna switch.
- Reports the current A/B antenna selection and the local/remote mode back to the remote controller as one UART byte (8N1, LSB first).
- Sits downstream of the input selection mux: its selected BCD outputs and remote flag drive this block, and O_txd drives the board TX line.
- Sends a frame on any change, on a periodic refresh, and on demand.

---
 rtl/sel_status_tx.sv | 186 ++++++++++++++++++
 tb/tb_sel_status_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_status_tx.sv
// sel_status_tx
// Serial status transmitter for the 6x2 antenna switch. Reports the current
// A/B antenna selection and the local/remote mode to the remote controller as
// one 8N1 UART byte, LSB first:
//     bit7 = 1 (sync marker), bit6 = remote, bits5:3 = A, bits2:0 = B.
// A frame is sent whenever the reported status differs from the last frame
// sent, on a single-cycle force request, and on a periodic idle refresh.
//
// Parameters:
//     CLK_DIV       clock cycles per UART bit (>= 2)
//     REFRESH_BITS  idle bit-periods between refresh frames (0 = no refresh)
//
// Ports:
//     I_clk          system clock
//     I_rst          asynchronous active-high reset
//     I_A, I_B       selected antenna for radio A / radio B (BCD, unchecked)
//     I_remote       1 = remote control active, 0 = local
//     I_force        single-cycle request to send a frame now
//     O_txd          UART serial output, idle high
//     O_busy         high from the first start-bit cycle to the last stop-bit cycle
//     O_frame_done   one-cycle pulse on the cycle after the stop bit ends

module sel_status_tx #(
    parameter int CLK_DIV      = 1042,
    parameter int REFRESH_BITS = 9600
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [2:0] I_A,
    input  logic [2:0] I_B,
    input  logic       I_remote,
    input  logic       I_force,
    output logic       O_txd,
    output logic       O_busy,
    output logic       O_frame_done
);

    localparam int BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REFRESH_W = (REFRESH_BITS > 0) ? $clog2(REFRESH_BITS + 1) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    localparam int                   REFRESH_LAST_INT = (REFRESH_BITS > 0) ? REFRESH_BITS - 1 : 0;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST     = REFRESH_W'(REFRESH_LAST_INT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_cnt;
    logic [REFRESH_W-1:0] refresh_cnt;
    logic [7:0]           shift_reg;
    logic [7:0]           last_sent;
    logic                 last_valid;
    logic                 pending;

    logic [7:0] snapshot;
    logic       changed;
    logic       baud_end;
    logic       refresh_fire;
    logic       send_req;
    logic       load;

    // Status byte as it would be sent right now, and whether it differs from
    // the last byte actually put on the line. Before the first frame the
    // last-sent copy is invalid, so everything counts as a change.
    assign snapshot = {1'b1, I_remote, I_A, I_B};
    assign changed  = !last_valid || (snapshot != last_sent);
    assign baud_end = (baud_cnt == BAUD_LAST);

    // The refresh timer only advances while idle with nothing pending, so it
    // fires on the last cycle of its REFRESH_BITS-th idle bit-period and the
    // frame is loaded in that same cycle.
    assign refresh_fire = (REFRESH_BITS != 0) && (state == ST_IDLE) && !pending
                          && baud_end && (refresh_cnt == REFRESH_LAST);

    // Any trigger seen in IDLE starts a frame immediately, so the start bit
    // appears on the line one cycle after the triggering cycle.
    assign send_req = pending || changed || I_force || refresh_fire;
    assign load     = (state == ST_IDLE) && send_req;

    // Pending latches triggers that arrive while a frame is on the line.
    // Several triggers during one frame collapse into a single follow-up
    // frame, which carries whatever the inputs are when it is loaded.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            pending <= 1'b1;
        end else if (load) begin
            pending <= 1'b0;
        end else if (changed || I_force) begin
            pending <= 1'b1;
        end
    end

    // Frame sequencer. The shift register is loaded exactly once per frame,
    // so input changes mid-frame never corrupt the byte being sent. All
    // outputs are registered; a reset mid-frame drops the line back to idle
    // high at once and no frame-done pulse follows.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state        <= ST_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            refresh_cnt  <= '0;
            shift_reg    <= '0;
            last_sent    <= '0;
            last_valid   <= 1'b0;
            O_txd        <= 1'b1;
            O_busy       <= 1'b0;
            O_frame_done <= 1'b0;
        end else begin
            O_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift_reg   <= snapshot;
                        last_sent   <= snapshot;
                        last_valid  <= 1'b1;
                        baud_cnt    <= '0;
                        bit_cnt     <= '0;
                        refresh_cnt <= '0;
                        O_txd       <= 1'b0;
                        O_busy      <= 1'b1;
                        state       <= ST_START;
                    end else if (!pending) begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (REFRESH_BITS != 0) begin
                                refresh_cnt <= refresh_cnt + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                end

                ST_START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        O_txd     <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            O_txd <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            O_txd     <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt     <= '0;
                        O_busy       <= 1'b0;
                        O_frame_done <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_status_tx.sv
// tb_sel_status_tx
// Testbench for sel_status_tx. Two instances share the same stimulus: one
// without periodic refresh and one refreshing every 3 idle bit-periods, both
// at 4 clock cycles per bit. A frame-level model predicts, for every cycle,
// the line level, busy and frame-done of each instance from the trigger
// rules; directed checks pin specific frames with hand-computed bytes.

module tb_sel_status_tx;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] a = 3'd5;
    logic [2:0] b = 3'd5;
    logic       remote = 1'b0;
    logic       force_req = 1'b0;

    logic txd0, busy0, done0;
    logic txd1, busy1, done1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sel_status_tx #(.CLK_DIV(D), .REFRESH_BITS(0)) u_dut_norefresh (
        .I_clk(clk), .I_rst(rst), .I_A(a), .I_B(b), .I_remote(remote),
        .I_force(force_req), .O_txd(txd0), .O_busy(busy0), .O_frame_done(done0)
    );

    sel_status_tx #(.CLK_DIV(D), .REFRESH_BITS(3)) u_dut_refresh (
        .I_clk(clk), .I_rst(rst), .I_A(a), .I_B(b), .I_remote(remote),
        .I_force(force_req), .O_txd(txd1), .O_busy(busy1), .O_frame_done(done1)
    );

    // Frame-level model state, one entry per instance. A frame is described
    // only by its start cycle and byte; the line waveform follows from that.
    int         refresh_bits[2] = '{0, 3};
    int         frame_start[2]  = '{-100000, -100000};
    bit         pend[2]         = '{1'b1, 1'b1};
    bit         last_valid[2]   = '{1'b0, 1'b0};
    logic [7:0] last_sent[2]    = '{8'h00, 8'h00};
    logic [7:0] frame_byte[2]   = '{8'h00, 8'h00};
    int         idle_cnt[2]     = '{0, 0};

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Model update: decides, from the inputs seen at each clock edge, whether
    // a frame starts on the next cycle or a trigger is remembered for later.
    initial begin
        logic [7:0] s;
        bit         due;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cyc = 0;
                for (int i = 0; i < 2; i++) begin
                    frame_start[i] = -100000;
                    pend[i]        = 1'b1;
                    last_valid[i]  = 1'b0;
                    idle_cnt[i]    = 0;
                end
            end else begin
                s = {1'b1, remote, a, b};
                for (int i = 0; i < 2; i++) begin
                    if (cyc >= frame_start[i] && cyc < frame_start[i] + 10 * D) begin
                        if (s != last_sent[i] || force_req) pend[i] = 1'b1;
                    end else begin
                        due = (refresh_bits[i] > 0) && !pend[i] && (idle_cnt[i] + 1 == refresh_bits[i] * D);
                        if (pend[i] || !last_valid[i] || s != last_sent[i] || force_req || due) begin
                            frame_start[i] = cyc + 1;
                            frame_byte[i]  = s;
                            last_sent[i]   = s;
                            last_valid[i]  = 1'b1;
                            pend[i]        = 1'b0;
                            idle_cnt[i]    = 0;
                        end else begin
                            idle_cnt[i] = idle_cnt[i] + 1;
                        end
                    end
                end
                cyc = cyc + 1;
            end
        end
    end

    // Expected {txd, busy, frame_done} for the current cycle.
    function automatic logic [2:0] expected_out(input int i);
        int n;
        int k;
        if (rst) return 3'b100;
        n = cyc - frame_start[i];
        if (n >= 0 && n < 10 * D) begin
            k = n / D;
            if (k == 0) return 3'b010;
            if (k <= 8) return {frame_byte[i][k-1], 2'b10};
            return 3'b110;
        end
        if (n == 10 * D) return 3'b101;
        return 3'b100;
    endfunction

    // Cycle-by-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_norefresh", {5'd0, txd0, busy0, done0}, {5'd0, expected_out(0)});
            checkOutput("model_refresh",   {5'd0, txd1, busy1, done1}, {5'd0, expected_out(1)});
        end
    end

    task automatic waitCyc(input int t);
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (cyc == t) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL wait_cycle: got cycle %0d, expected cycle %0d", cyc, t);
    endtask

    task automatic applyStimulus(input int t, input logic [2:0] na, input logic [2:0] nb,
                                 input logic nr, input logic nf);
        waitCyc(t);
        a         = na;
        b         = nb;
        remote    = nr;
        force_req = nf;
    endtask

    // Samples the middle of each bit of a frame starting at 'start' and the
    // frame-done pulse 10 bit-periods later, against a literal byte.
    task automatic checkFrame(input bit which, input int start, input logic [7:0] byte_val, input string name);
        logic [9:0] line;
        logic       bit_now;
        line = {1'b1, byte_val, 1'b0};
        for (int k = 0; k < 10; k++) begin
            waitCyc(start + D * k + D / 2);
            bit_now = which ? txd1 : txd0;
            checkOutput(name, {7'd0, bit_now}, {7'd0, line[k]});
        end
        waitCyc(start + 10 * D);
        checkOutput({name, "_done"}, {7'd0, which ? done1 : done0}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f;
        int c;
        bit seen;

        $display("[TB] starting");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd",  {7'd0, txd0},  8'd1);
        checkOutput("reset_busy", {7'd0, busy0}, 8'd0);
        checkOutput("reset_done", {7'd0, done0}, 8'd0);
        #2 rst = 1'b0;

        // First frame after reset: A=5, B=5, local -> 0xAD, start bit at cycle 1.
        checkFrame(1'b0, 1, 8'hAD, "first_frame");
        checkOutput("first_busy_end", {7'd0, busy0}, 8'd0);

        // Local -> remote: one frame 0xED, then silence without refresh.
        applyStimulus(60, 3'd5, 3'd5, 1'b1, 1'b0);
        checkFrame(1'b0, 61, 8'hED, "remote_frame");
        waitCyc(150);
        checkOutput("quiet_busy", {7'd0, busy0}, 8'd0);
        checkOutput("quiet_txd",  {7'd0, txd0},  8'd1);

        // Forced frame; B changes during data bit 3 and must not disturb it.
        applyStimulus(160, 3'd5, 3'd5, 1'b1, 1'b1);
        applyStimulus(161, 3'd5, 3'd5, 1'b1, 1'b0);
        fork
            checkFrame(1'b0, 161, 8'hED, "hold_frame");
            applyStimulus(178, 3'd5, 3'd0, 1'b1, 1'b0);
        join

        // Back-to-back 0xE8; two forces and an A change inside it coalesce.
        fork
            checkFrame(1'b0, 202, 8'hE8, "changed_frame");
            begin
                applyStimulus(207, 3'd5, 3'd0, 1'b1, 1'b1);
                applyStimulus(208, 3'd5, 3'd0, 1'b1, 1'b0);
                applyStimulus(212, 3'd3, 3'd0, 1'b1, 1'b0);
                applyStimulus(222, 3'd3, 3'd0, 1'b1, 1'b1);
                applyStimulus(223, 3'd3, 3'd0, 1'b1, 1'b0);
            end
        join
        checkFrame(1'b0, 243, 8'hD8, "coalesced_frame");
        waitCyc(300);
        checkOutput("coalesced_once", {7'd0, busy0}, 8'd0);

        // Refresh instance: repeat frame 12 cycles after frame done.
        waitCyc(310);
        seen = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("refresh_seen", {7'd0, seen}, 8'd1);
        f = cyc;
        waitCyc(f + 11);
        checkOutput("refresh_gap_txd",  {7'd0, txd1},  8'd1);
        checkOutput("refresh_gap_busy", {7'd0, busy1}, 8'd0);
        waitCyc(f + 12);
        checkOutput("refresh_start_txd",  {7'd0, txd1},  8'd0);
        checkOutput("refresh_start_busy", {7'd0, busy1}, 8'd1);
        checkFrame(1'b1, f + 12, 8'hD8, "refresh_frame");
        waitCyc(f + 63);
        checkOutput("refresh2_gap", {7'd0, txd1}, 8'd1);
        waitCyc(f + 65);
        checkOutput("refresh2_start", {7'd0, txd1}, 8'd0);
        checkOutput("norefresh_idle", {7'd0, busy0}, 8'd0);

        // Reset in the middle of the data bits aborts the frame at once.
        c = cyc + 5;
        applyStimulus(c, 3'd3, 3'd0, 1'b1, 1'b1);
        applyStimulus(c + 1, 3'd3, 3'd0, 1'b1, 1'b0);
        waitCyc(c + 11);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_txd",  {7'd0, txd0},  8'd1);
        checkOutput("abort_busy", {7'd0, busy0}, 8'd0);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            checkOutput("abort_no_done", {7'd0, done0}, 8'd0);
        end
        #2 rst = 1'b0;
        checkFrame(1'b0, 1, 8'hD8, "post_reset_frame");
        waitCyc(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
